adding_machine_controller: RTL and testbench

- Control unit for the 8-bit accumulator adding-machine datapath.
- Sequences fetch/decode/execute, drives every datapath control strobe, and runs a ready-based read handshake with program memory.
- Reads the instruction register (opcode IR[7:6], operand IR[5:0]) back from the datapath; sits beside the datapath under the top level.

---
 rtl/adding_machine_pkg.sv | 67 ++++++
 rtl/adding_machine_controller_mem_wait_timer.sv | 43 ++++
 rtl/adding_machine_controller.sv | 146 ++++++++++++++
 tb/tb_adding_machine_controller.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adding_machine_pkg.sv
// adding_machine_pkg
// Shared definitions for the adding-machine control unit: opcode values,
// instruction-register field positions, the controller state encoding and
// the per-state Moore control word.
// No ports (package).

package adding_machine_pkg;

    // Opcodes carried in IR[7:6]
    localparam logic [1:0] OP_LDA  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HLT  = 2'b11;

    // Instruction register field positions
    localparam int IR_OP_HI = 7;
    localparam int IR_OP_LO = 6;
    localparam int IR_ADR_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC_LDA = 3'd3,
        ST_EXEC_ADD = 3'd4,
        ST_EXEC_JMP = 3'd5,
        ST_HALT     = 3'd6,
        ST_ERROR    = 3'd7
    } state_t;

    // Control outputs that depend only on the state. The strobes that are
    // qualified by mem_rdy are derived from mem_rd/pc_on_adr/ir_on_adr in
    // the top level instead.
    typedef struct packed {
        logic mem_rd;
        logic pc_on_adr;
        logic ir_on_adr;
        logic clr_pc;
        logic ld_pc;
        logic do_add;
        logic halted;
        logic error;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_IDLE:     c.clr_pc = 1'b1;
            ST_FETCH: begin
                c.mem_rd    = 1'b1;
                c.pc_on_adr = 1'b1;
            end
            ST_EXEC_LDA: begin
                c.mem_rd    = 1'b1;
                c.ir_on_adr = 1'b1;
            end
            ST_EXEC_ADD: c.do_add = 1'b1;
            ST_EXEC_JMP: c.ld_pc  = 1'b1;
            ST_HALT:     c.halted = 1'b1;
            ST_ERROR:    c.error  = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/adding_machine_controller_mem_wait_timer.sv
// mem_wait_timer
// Counts wait states of a memory read and flags a timeout.
// Ports:
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   mem_rd   in   a read request is outstanding this cycle
//   mem_rdy  in   memory returns data this cycle
//   timeout  out  this cycle is the TIMEOUT-th consecutive wait state

module mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic mem_rd,
    input  logic mem_rdy,
    output logic timeout
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] wait_cnt;

    // Every memory state is entered from a cycle that either had no read
    // outstanding or completed one, so clearing on those two conditions
    // also gives the clear-on-entry behaviour.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!mem_rd || mem_rdy) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_ONE;
        end
    end

    // The counter reaches TIMEOUT on the edge that ends this wait cycle;
    // a mem_rdy in the same cycle suppresses the timeout.
    assign timeout = mem_rd && !mem_rdy && (wait_cnt >= LAST_WAIT);

endmodule

// File: rtl/adding_machine_controller.sv
// adding_machine_controller
// Control unit for the 8-bit accumulator adding machine. Sequences
// fetch/decode/execute, drives the datapath strobes and runs a ready-based
// read handshake with program memory.
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle pulse, begins execution from address 0
//   ir_in      in   instruction register from the datapath
//   mem_rdy    in   memory read data valid this cycle
//   mem_rd     out  memory read request
//   load_IR    out  IR load strobe
//   load_acc   out  accumulator load strobe
//   sel_alu    out  accumulator mux selects ALU result
//   sel_bus    out  accumulator mux selects Data_bus_in
//   pass_add   out  ALU add (1) / pass (0)
//   ir_on_adr  out  address mux selects IR[5:0]
//   pc_on_adr  out  address mux selects PC
//   ld_pc      out  PC loads IR[5:0]
//   clr_pc     out  PC clears to 0
//   inc_pc     out  PC increments
//   halted     out  HALT state
//   error      out  ERROR state (memory timeout)

module adding_machine_controller
    import adding_machine_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] ir_in,
    input  logic       mem_rdy,
    output logic       mem_rd,
    output logic       load_IR,
    output logic       load_acc,
    output logic       sel_alu,
    output logic       sel_bus,
    output logic       pass_add,
    output logic       ir_on_adr,
    output logic       pc_on_adr,
    output logic       ld_pc,
    output logic       clr_pc,
    output logic       inc_pc,
    output logic       halted,
    output logic       error
);

    state_t      state;
    state_t      next_state;
    ctrl_t       ctrl_q;
    logic        timeout;
    logic        lda_done;
    logic [1:0]  opcode;
    logic        ir_adr_unused;

    assign opcode = ir_in[IR_OP_HI:IR_OP_LO];

    // The operand field is routed to the PC and address mux inside the
    // datapath; the controller only looks at the opcode.
    assign ir_adr_unused = ^ir_in[IR_ADR_W-1:0];

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .mem_rd  (ctrl_q.mem_rd),
        .mem_rdy (mem_rdy),
        .timeout (timeout)
    );

    // Next-state logic. In the memory states a completing transfer takes
    // priority over a timeout in the same cycle.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_rdy)      next_state = ST_DECODE;
                else if (timeout) next_state = ST_ERROR;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_LDA:  next_state = ST_EXEC_LDA;
                    OP_ADDI: next_state = ST_EXEC_ADD;
                    OP_JMP:  next_state = ST_EXEC_JMP;
                    default: next_state = ST_HALT;
                endcase
            end
            ST_EXEC_LDA: begin
                if (mem_rdy)      next_state = ST_FETCH;
                else if (timeout) next_state = ST_ERROR;
            end
            ST_EXEC_ADD: next_state = ST_FETCH;
            ST_EXEC_JMP: next_state = ST_FETCH;
            ST_HALT: begin
                if (start) next_state = ST_IDLE;
            end
            ST_ERROR: begin
                if (start) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State register with the Moore control word registered alongside it,
    // decoded from the state being entered so it is glitch-free.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ctrl_q <= state_ctrl(ST_IDLE);
        end else begin
            state  <= next_state;
            ctrl_q <= state_ctrl(next_state);
        end
    end

    assign mem_rd    = ctrl_q.mem_rd;
    assign pc_on_adr = ctrl_q.pc_on_adr;
    assign ir_on_adr = ctrl_q.ir_on_adr;
    assign clr_pc    = ctrl_q.clr_pc;
    assign ld_pc     = ctrl_q.ld_pc;
    assign halted    = ctrl_q.halted;
    assign error     = ctrl_q.error;

    // Load strobes only fire with mem_rdy, so an interrupted read never
    // disturbs IR, PC or the accumulator.
    assign load_IR  = ctrl_q.pc_on_adr & mem_rdy;
    assign inc_pc   = ctrl_q.pc_on_adr & mem_rdy;
    assign lda_done = ctrl_q.ir_on_adr & mem_rdy;
    assign sel_bus  = lda_done;
    assign load_acc = lda_done | ctrl_q.do_add;
    assign sel_alu  = ctrl_q.do_add;
    assign pass_add = ctrl_q.do_add;

    assert property (@(posedge clock) disable iff (!reset) !(sel_alu && sel_bus));
    assert property (@(posedge clock) disable iff (!reset) !(ir_on_adr && pc_on_adr));
    assert property (@(posedge clock) disable iff (!reset) $onehot0({ld_pc, clr_pc, inc_pc}));

endmodule

// File: tb/tb_adding_machine_controller.sv
// tb_adding_machine_controller
// Randomised programs are turned into an expected per-cycle trace of the
// controller outputs from the instruction-level rules; the trace is then
// played into the controller and every cycle is compared.

module tb_adding_machine_controller;

    localparam int TIMEOUT = 15;

    // Output vector bit masks, order matches obs_vec below
    localparam logic [12:0] M_MEM_RD    = 13'h1000;
    localparam logic [12:0] M_LOAD_IR   = 13'h0800;
    localparam logic [12:0] M_LOAD_ACC  = 13'h0400;
    localparam logic [12:0] M_SEL_ALU   = 13'h0200;
    localparam logic [12:0] M_SEL_BUS   = 13'h0100;
    localparam logic [12:0] M_PASS_ADD  = 13'h0080;
    localparam logic [12:0] M_IR_ON_ADR = 13'h0040;
    localparam logic [12:0] M_PC_ON_ADR = 13'h0020;
    localparam logic [12:0] M_LD_PC     = 13'h0010;
    localparam logic [12:0] M_CLR_PC    = 13'h0008;
    localparam logic [12:0] M_INC_PC    = 13'h0004;
    localparam logic [12:0] M_HALTED    = 13'h0002;
    localparam logic [12:0] M_ERROR     = 13'h0001;

    localparam logic [12:0] V_IDLE       = M_CLR_PC;
    localparam logic [12:0] V_FETCH_WAIT = M_MEM_RD | M_PC_ON_ADR;
    localparam logic [12:0] V_FETCH_DONE = M_MEM_RD | M_PC_ON_ADR | M_LOAD_IR | M_INC_PC;
    localparam logic [12:0] V_DECODE     = 13'h0000;
    localparam logic [12:0] V_LDA_WAIT   = M_MEM_RD | M_IR_ON_ADR;
    localparam logic [12:0] V_LDA_DONE   = M_MEM_RD | M_IR_ON_ADR | M_SEL_BUS | M_LOAD_ACC;
    localparam logic [12:0] V_ADD        = M_SEL_ALU | M_PASS_ADD | M_LOAD_ACC;
    localparam logic [12:0] V_JMP        = M_LD_PC;
    localparam logic [12:0] V_HALT       = M_HALTED;
    localparam logic [12:0] V_ERROR      = M_ERROR;

    typedef struct packed {
        logic [7:0]  ir;
        logic        rdy;
        logic        start;
        logic [12:0] exp;
    } step_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ir_in;
    logic       mem_rdy;
    logic       mem_rd, load_IR, load_acc, sel_alu, sel_bus, pass_add;
    logic       ir_on_adr, pc_on_adr, ld_pc, clr_pc, inc_pc, halted, error;
    logic [12:0] obs_vec;

    step_t plan[$];
    string tags[$];
    int    check_count = 0;
    int    error_count = 0;

    adding_machine_controller #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .ir_in     (ir_in),
        .mem_rdy   (mem_rdy),
        .mem_rd    (mem_rd),
        .load_IR   (load_IR),
        .load_acc  (load_acc),
        .sel_alu   (sel_alu),
        .sel_bus   (sel_bus),
        .pass_add  (pass_add),
        .ir_on_adr (ir_on_adr),
        .pc_on_adr (pc_on_adr),
        .ld_pc     (ld_pc),
        .clr_pc    (clr_pc),
        .inc_pc    (inc_pc),
        .halted    (halted),
        .error     (error)
    );

    always #5 clock = ~clock;

    assign obs_vec = {mem_rd, load_IR, load_acc, sel_alu, sel_bus, pass_add,
                      ir_on_adr, pc_on_adr, ld_pc, clr_pc, inc_pc, halted, error};

    task automatic checkOutput(input string tag, input logic [12:0] observed,
                               input logic [12:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic [7:0] ir, input logic rdy,
                        input logic st, input logic [12:0] exp);
        step_t s;
        s.ir    = ir;
        s.rdy   = rdy;
        s.start = st;
        s.exp   = exp;
        plan.push_back(s);
        tags.push_back(tag);
    endtask

    // Idle cycles then the start pulse
    task automatic plan_idle(input int n);
        for (int i = 0; i < n; i++) push("idle", 8'($urandom), rnd_bit(), 1'b0, V_IDLE);
        push("idle_start", 8'($urandom), rnd_bit(), 1'b1, V_IDLE);
    endtask

    // Error cycles then the start pulse that leaves
    task automatic plan_error(input int n);
        for (int i = 0; i < n; i++) push("error", 8'($urandom), rnd_bit(), 1'b0, V_ERROR);
        push("error_start", 8'($urandom), rnd_bit(), 1'b1, V_ERROR);
    endtask

    // One memory read: waits cycles without mem_rdy, then completion, or
    // a timeout after TIMEOUT waits. start is junk here and must be ignored.
    task automatic plan_read(input logic [7:0] ir, input int waits, input logic is_fetch,
                             output bit ok);
        logic [12:0] wait_v;
        logic [12:0] done_v;
        wait_v = is_fetch ? V_FETCH_WAIT : V_LDA_WAIT;
        done_v = is_fetch ? V_FETCH_DONE : V_LDA_DONE;
        if (waits >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) push("read_wait", ir, 1'b0, rnd_bit(), wait_v);
            plan_error($urandom_range(0, 3));
            ok = 1'b0;
        end else begin
            for (int i = 0; i < waits; i++) push("read_wait", ir, 1'b0, rnd_bit(), wait_v);
            push(is_fetch ? "fetch_done" : "lda_done", ir, 1'b1, rnd_bit(), done_v);
            ok = 1'b1;
        end
    endtask

    // A whole instruction; cont=0 when execution stopped (HALT or ERROR)
    task automatic plan_instr(input logic [7:0] ir, input int fw, input int lw,
                              input int halt_n, output bit cont);
        bit ok;
        logic [7:0] ir_v;
        ir_v = ir;
        cont = 1'b0;
        plan_read(ir_v, fw, 1'b1, ok);
        if (!ok) return;
        push("decode", ir_v, rnd_bit(), rnd_bit(), V_DECODE);
        case (ir_v[7:6])
            2'b00: begin
                plan_read(ir_v, lw, 1'b0, ok);
                cont = ok;
            end
            2'b01: begin
                push("exec_add", ir_v, rnd_bit(), rnd_bit(), V_ADD);
                cont = 1'b1;
            end
            2'b10: begin
                push("exec_jmp", ir_v, rnd_bit(), rnd_bit(), V_JMP);
                cont = 1'b1;
            end
            default: begin
                for (int i = 0; i < halt_n; i++) push("halt", ir_v, rnd_bit(), 1'b0, V_HALT);
                push("halt_start", ir_v, rnd_bit(), 1'b1, V_HALT);
            end
        endcase
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 11));
        if (r < 7) return r % 4;
        if (r < 10) return TIMEOUT - 1;
        return TIMEOUT;
    endfunction

    // Drive one planned cycle and compare the outputs after inputs settle
    task automatic applyStimulus(input step_t s, input string tag);
        @(negedge clock);
        ir_in   = s.ir;
        mem_rdy = s.rdy;
        start   = s.start;
        #1;
        checkOutput(tag, obs_vec, s.exp);
    endtask

    task automatic run_plan();
        while (plan.size() > 0) begin
            applyStimulus(plan.pop_front(), tags.pop_front());
        end
    endtask

    initial begin
        bit cont;
        reset   = 1'b0;
        start   = 1'b0;
        mem_rdy = 1'b0;
        ir_in   = 8'h00;

        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            mem_rdy = rnd_bit();
            #1;
            checkOutput("in_reset", obs_vec, V_IDLE);
        end
        @(negedge clock);
        reset   = 1'b1;
        mem_rdy = 1'b0;
        #1;
        checkOutput("after_reset", obs_vec, V_IDLE);

        // Directed: ADDI 5, LDA 10 with three waits, JMP 31, fetch timeout
        plan_idle(1);
        plan_instr(8'h45, 0, 0, 0, cont);
        plan_instr(8'h0A, 0, 3, 0, cont);
        plan_instr(8'h9F, 0, 0, 0, cont);
        plan_instr(8'h45, TIMEOUT, 0, 0, cont);
        // Directed: ready on the last allowed cycle, then HLT for 20 cycles
        plan_idle(0);
        plan_instr(8'hC0, TIMEOUT - 1, 0, 20, cont);
        run_plan();

        // Random programs
        for (int sess = 0; sess < 14; sess++) begin
            plan_idle($urandom_range(0, 2));
            cont = 1'b1;
            for (int n = 0; n < 6 && cont; n++) begin
                plan_instr(8'($urandom), pick_wait(), pick_wait(), $urandom_range(0, 4), cont);
            end
            if (cont) plan_instr(8'hC0 | 8'($urandom_range(0, 63)), pick_wait(), 0, 1, cont);
            run_plan();
        end

        // Reset in the middle of an LDA read
        plan_idle(0);
        plan_instr(8'h0A, 0, 0, 0, cont);
        while (plan.size() > 0 && tags[0] != "lda_done") begin
            applyStimulus(plan.pop_front(), tags.pop_front());
        end
        plan.delete();
        tags.delete();
        applyStimulus('{ir: 8'h0A, rdy: 1'b0, start: 1'b0, exp: V_LDA_WAIT}, "lda_wait_pre_reset");
        @(negedge clock);
        mem_rdy = 1'b1;
        #1;
        checkOutput("lda_ready_pre_reset", obs_vec, V_LDA_DONE);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs", obs_vec, V_IDLE);
        checkOutput("async_reset_load_acc", {12'b0, load_acc}, 13'h0000);
        @(negedge clock);
        #1;
        checkOutput("held_reset", obs_vec, V_IDLE);
        reset   = 1'b1;
        mem_rdy = 1'b0;
        applyStimulus('{ir: 8'h00, rdy: 1'b1, start: 1'b0, exp: V_IDLE}, "idle_after_mid_reset");

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
